// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module  : muldiv_pkg
// Purpose : M-extension op codes, unit state encoding and op decode helpers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

   localparam logic [4:0] OP_MUL    = 5'b00001;
   localparam logic [4:0] OP_MULH   = 5'b00101;
   localparam logic [4:0] OP_MULHSU = 5'b01101;
   localparam logic [4:0] OP_MULHU  = 5'b01001;
   localparam logic [4:0] OP_DIV    = 5'b10001;
   localparam logic [4:0] OP_DIVU   = 5'b10101;
   localparam logic [4:0] OP_REM    = 5'b11001;
   localparam logic [4:0] OP_REMU   = 5'b11101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic logic is_mul(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
   endfunction

   function automatic logic is_div(input logic [4:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_rem(input logic [4:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_signed_a(input logic [4:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input logic [4:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_divider.sv
// ============================================================================
// Module  : muldiv_divider
// Purpose : Unsigned restoring radix-2 divider, one quotient bit per cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CNT_W = $clog2(XLEN + 1);

   logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [XLEN:0]    w_shift, w_sub;

   always_comb begin
      w_shift = {rem_q, quo_q[XLEN-1]};
      // MSB of the trial difference is the borrow: set when the divisor does not fit
      w_sub   = w_shift - {1'b0, dvs_q};
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (abort) begin
         busy_d = 1'b0;
      end else if (start) begin
         quo_d  = dividend;
         rem_d  = '0;
         dvs_d  = divisor;
         cnt_d  = CNT_W'(XLEN);
         busy_d = 1'b1;
      end else if (busy_q) begin
         quo_d = {quo_q[XLEN-2:0], ~w_sub[XLEN]};
         rem_d = w_sub[XLEN] ? w_shift[XLEN-1:0] : w_sub[XLEN-1:0];
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Purpose : Multi-cycle RV32M/RV64M multiply/divide unit, valid/ready on both sides.
//           Define MULDIV_EARLY_OUT_EN for the short-latency trivial-divide path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 2,
   parameter int TAG_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       alu_ctrl,
   input  logic [XLEN-1:0]  op_a,
   input  logic [XLEN-1:0]  op_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic             zero,
   output logic [TAG_W-1:0] out_tag
);

   localparam int              CNT_W   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [XLEN-1:0] C_MIN   = {1'b1, {(XLEN-1){1'b0}}};

   state_e           state_q, state_d;
   logic [4:0]       op_q, op_d;
   logic [XLEN-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
   logic [TAG_W-1:0] tag_q, tag_d, out_tag_q, out_tag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_start;

   // Multiplier: product of the port operands, delayed by a register chain
   logic [2*XLEN-1:0] w_a_wide, w_b_wide, w_prod, w_mul_tail;
   logic [4:0]        w_mul_op;
   logic [XLEN-1:0]   w_mul_res;

   assign w_a_wide = {{XLEN{is_signed_a(alu_ctrl) & op_a[XLEN-1]}}, op_a};
   assign w_b_wide = {{XLEN{is_signed_b(alu_ctrl) & op_b[XLEN-1]}}, op_b};
   assign w_prod   = w_a_wide * w_b_wide;

   generate
      if (MUL_LAT == 1) begin : g_mul_comb
         assign w_mul_tail = w_prod;
      end else begin : g_mul_pipe
         logic [2*XLEN-1:0] pipe_q [MUL_LAT-1];
         logic [2*XLEN-1:0] pipe_d [MUL_LAT-1];
         always_comb begin
            pipe_d[0] = w_prod;
            for (int i = 1; i < MUL_LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
         end
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= '0;
            end else begin
               for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_d[i];
            end
         end
         assign w_mul_tail = pipe_q[MUL_LAT-2];
      end
   endgenerate

   assign w_mul_op  = (MUL_LAT == 1) ? alu_ctrl : op_q;
   assign w_mul_res = (w_mul_op == OP_MUL) ? w_mul_tail[XLEN-1:0] : w_mul_tail[2*XLEN-1:XLEN];

   // Divider: magnitudes in from the ports, sign fix-up from the held operands
   logic            w_sa_in, w_sb_in, w_sa, w_sb, w_b_zero;
   logic [XLEN-1:0] w_mag_a, w_mag_b, w_div_quo, w_div_rem, w_quo_fix, w_rem_fix, w_div_res;
   logic            w_div_busy, w_div_done;

   assign w_sa_in  = is_signed_a(alu_ctrl) & op_a[XLEN-1];
   assign w_sb_in  = is_signed_b(alu_ctrl) & op_b[XLEN-1];
   assign w_mag_a  = w_sa_in ? -op_a : op_a;
   assign w_mag_b  = w_sb_in ? -op_b : op_b;

   assign w_sa      = is_signed_a(op_q) & a_q[XLEN-1];
   assign w_sb      = is_signed_b(op_q) & b_q[XLEN-1];
   assign w_b_zero  = (b_q == '0);
   assign w_quo_fix = w_b_zero ? '1 : ((w_sa ^ w_sb) ? -w_div_quo : w_div_quo);
   assign w_rem_fix = w_sa ? -w_div_rem : w_div_rem;
   assign w_div_res = is_rem(op_q) ? w_rem_fix : w_quo_fix;

   muldiv_divider #(.XLEN(XLEN)) u_divider (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .abort     (flush),
      .dividend  (w_mag_a),
      .divisor   (w_mag_b),
      .busy      (w_div_busy),
      .done      (w_div_done),
      .quotient  (w_div_quo),
      .remainder (w_div_rem)
   );

`ifdef MULDIV_EARLY_OUT_EN
   logic            early_q, early_d, w_early_in, w_ovf;
   logic [XLEN-1:0] w_early_res;

   assign w_early_in  = (op_b == '0)
                      | (is_signed_a(alu_ctrl) & (op_a == C_MIN) & (op_b == '1))
                      | (w_mag_a < w_mag_b);
   assign w_ovf       = is_signed_a(op_q) & (a_q == C_MIN) & (b_q == '1);
   // Only three shortcut cases exist: /0, MIN/-1, and |a| < |b| (quotient 0, remainder a)
   assign w_early_res = is_rem(op_q) ? (w_ovf ? '0 : a_q)
                                     : (w_b_zero ? '1 : (w_ovf ? a_q : '0));
`else
   logic [XLEN-1:0] w_unused_min;
   assign w_unused_min = C_MIN;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      tag_d     = tag_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      out_tag_d = out_tag_q;
      div_start = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      early_d   = early_q;
`endif
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_d  = alu_ctrl;
                  a_d   = op_a;
                  b_d   = op_b;
                  tag_d = in_tag;
                  cnt_d = '0;
                  if (is_mul(alu_ctrl)) begin
                     if (MUL_LAT == 1) begin
                        state_d   = DONE;
                        result_d  = w_mul_res;
                        out_tag_d = in_tag;
                     end else begin
                        state_d = MUL;
                     end
                  end else if (is_div(alu_ctrl)) begin
                     state_d = DIV;
`ifdef MULDIV_EARLY_OUT_EN
                     early_d   = w_early_in;
                     div_start = ~w_early_in;
`else
                     div_start = 1'b1;
`endif
                  end else begin
                     state_d   = DONE;
                     result_d  = '0;
                     out_tag_d = in_tag;
                  end
               end
            end
            MUL: begin
               if (cnt_q == CNT_W'(MUL_LAT - 2)) begin
                  state_d   = DONE;
                  result_d  = w_mul_res;
                  out_tag_d = tag_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DIV: begin
`ifdef MULDIV_EARLY_OUT_EN
               if (early_q) begin
                  state_d   = DONE;
                  result_d  = w_early_res;
                  out_tag_d = tag_q;
               end else
`endif
               if (w_div_done && !w_div_busy) begin
                  state_d   = DONE;
                  result_d  = w_div_res;
                  out_tag_d = tag_q;
               end
            end
            DONE: begin
               if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         tag_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         out_tag_q <= '0;
`ifdef MULDIV_EARLY_OUT_EN
         early_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         tag_q     <= tag_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         out_tag_q <= out_tag_d;
`ifdef MULDIV_EARLY_OUT_EN
         early_q   <= early_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = (result_q == '0);
   assign out_tag   = out_tag_q;

endmodule

`default_nettype wire
